// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - core request/response and data_memory signals of the load/store unit
interface load_store_unit_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_WIDTH = 7
);
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_we;
    logic [1:0]             req_size;
    logic                   req_unsigned;
    logic [31:0]            req_addr;
    logic [DATA_WIDTH-1:0]  req_wdata;
    logic                   resp_valid;
    logic [DATA_WIDTH-1:0]  resp_rdata;
    logic                   resp_err;
    logic [INDEX_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0]  mem_write_data;
    logic                   mem_wr;
    logic [DATA_WIDTH-1:0]  mem_read_data;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_address, mem_write_data, mem_wr
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_address, mem_write_data, mem_wr
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit with sub-word read-modify-write
module load_store_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int DATA_DEPTH  = 128,
    parameter int INDEX_WIDTH = $clog2(DATA_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    load_store_unit_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, MERGE_WR, RESP} state_t;

    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DATA_DEPTH);

    state_t                 state, next_state;
    logic                   we_q, uns_q, err_q;
    logic [1:0]             size_q, lane_q;
    logic [INDEX_WIDTH-1:0] index_q;
    logic [DATA_WIDTH-1:0]  wdata_q, data_q;

    logic                   accept, req_err;
    logic [7:0]             lane_byte;
    logic [15:0]            lane_half;
    logic [DATA_WIDTH-1:0]  load_ext, merged;

    assign accept = bus.req_valid && bus.req_ready;

    always_comb begin
        req_err = (bus.req_size == 2'b11)
               || (bus.req_size == 2'b01 && bus.req_addr[0])
               || (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00)
               || (bus.req_addr >= ADDR_LIMIT);
    end

    // Lane extraction and sub-word merge both operate on the word currently on mem_read_data.
    always_comb begin
        lane_byte = bus.mem_read_data[{lane_q, 3'b000} +: 8];
        lane_half = lane_q[1] ? bus.mem_read_data[31:16] : bus.mem_read_data[15:0];
        case (size_q)
            2'b00:   load_ext = uns_q ? {{(DATA_WIDTH-8){1'b0}}, lane_byte}
                                      : {{(DATA_WIDTH-8){lane_byte[7]}}, lane_byte};
            2'b01:   load_ext = uns_q ? {{(DATA_WIDTH-16){1'b0}}, lane_half}
                                      : {{(DATA_WIDTH-16){lane_half[15]}}, lane_half};
            default: load_ext = bus.mem_read_data;
        endcase
        merged = bus.mem_read_data;
        if (size_q == 2'b00)
            merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        else
            merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= 2'b00;
            lane_q  <= 2'b00;
            index_q <= '0;
            wdata_q <= '0;
            data_q  <= '0;
        end else if (accept) begin
            we_q    <= bus.req_we;
            uns_q   <= bus.req_unsigned;
            err_q   <= req_err;
            size_q  <= bus.req_size;
            lane_q  <= bus.req_addr[1:0];
            index_q <= bus.req_addr[INDEX_WIDTH+1:2];
            wdata_q <= bus.req_wdata;
            data_q  <= '0;
        end else if (state == ACCESS) begin
            // data_q holds either the extended load result or the merged store word.
            if (!we_q)
                data_q <= load_ext;
            else if (size_q != 2'b10)
                data_q <= merged;
        end
    end

    always_comb begin
        next_state         = state;
        bus.req_ready      = 1'b0;
        bus.resp_valid     = 1'b0;
        bus.resp_err       = 1'b0;
        bus.resp_rdata     = '0;
        bus.mem_address    = '0;
        bus.mem_write_data = '0;
        bus.mem_wr         = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = !rst;
                if (accept)
                    next_state = req_err ? RESP : ACCESS;
            end
            ACCESS: begin
                bus.mem_address = index_q;
                if (!we_q) begin
                    next_state = RESP;
                end else if (size_q == 2'b10) begin
                    bus.mem_wr         = 1'b1;
                    bus.mem_write_data = wdata_q;
                    next_state         = RESP;
                end else begin
                    next_state = MERGE_WR;
                end
            end
            MERGE_WR: begin
                bus.mem_address    = index_q;
                bus.mem_wr         = 1'b1;
                bus.mem_write_data = data_q;
                next_state         = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_err   = err_q;
                if (!we_q && !err_q)
                    bus.resp_rdata = data_q;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit with a word memory model
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;

    load_store_unit_if #(.DATA_WIDTH(32), .INDEX_WIDTH(7)) bus ();

    load_store_unit #(.DATA_WIDTH(32), .DATA_DEPTH(128)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:127];
    int          wr_count     = 0;
    int          resp_count   = 0;
    int          accept_count = 0;
    logic [6:0]  last_addr    = '0;
    logic [31:0] last_data    = '0;

    assign bus.mem_read_data = mem[bus.mem_address];

    always @(posedge clk) begin
        if (bus.mem_wr) begin
            mem[bus.mem_address] <= bus.mem_write_data;
            last_addr            <= bus.mem_address;
            last_data            <= bus.mem_write_data;
            wr_count             <= wr_count + 1;
        end
        if (bus.resp_valid)
            resp_count <= resp_count + 1;
        if (bus.req_valid && bus.req_ready)
            accept_count <= accept_count + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat, output logic [31:0] rdata, output logic err);
        int n;
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            n++;
            if (bus.resp_valid) break;
        end
        lat   = n;
        rdata = bus.resp_rdata;
        err   = bus.resp_err;
    endtask

    typedef struct {
        string       tag;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] rdata;
        logic        err;
        int          writes;
        logic [6:0]  waddr;
        logic [31:0] wval;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int          lat, w0, r0, a0;
        logic [31:0] rdata;
        logic        err;

        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;

        #2;
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
        check("rst_mem_address", 32'(bus.mem_address), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("ready_after_rst", 32'(bus.req_ready), 32'd1);

        //            tag              we    size  uns  addr          wdata          lat rdata          err  wr waddr wval
        vecs.push_back('{"st_word",     1'b1, 2'd2, 1'b0, 32'h14,  32'hDEADBEEF, 2, 32'h0,        1'b0, 1, 7'd5,   32'hDEADBEEF});
        vecs.push_back('{"ld_word",     1'b0, 2'd2, 1'b1, 32'h14,  32'h0,        2, 32'hDEADBEEF, 1'b0, 0, 7'd0,   32'h0});
        vecs.push_back('{"st_byte",     1'b1, 2'd0, 1'b0, 32'h16,  32'hABCD0055, 3, 32'h0,        1'b0, 1, 7'd5,   32'hDE55BEEF});
        vecs.push_back('{"ld_sbyte",    1'b0, 2'd0, 1'b0, 32'h17,  32'h0,        2, 32'hFFFFFFDE, 1'b0, 0, 7'd0,   32'h0});
        vecs.push_back('{"ld_ubyte",    1'b0, 2'd0, 1'b1, 32'h17,  32'h0,        2, 32'h000000DE, 1'b0, 0, 7'd0,   32'h0});
        vecs.push_back('{"ld_shalf",    1'b0, 2'd1, 1'b0, 32'h16,  32'h0,        2, 32'hFFFFDE55, 1'b0, 0, 7'd0,   32'h0});
        vecs.push_back('{"ld_uhalf_lo", 1'b0, 2'd1, 1'b1, 32'h14,  32'h0,        2, 32'h0000BEEF, 1'b0, 0, 7'd0,   32'h0});
        vecs.push_back('{"st_half_lo",  1'b1, 2'd1, 1'b0, 32'h14,  32'h12347766, 3, 32'h0,        1'b0, 1, 7'd5,   32'hDE557766});
        vecs.push_back('{"ld_sbyte0",   1'b0, 2'd0, 1'b0, 32'h14,  32'h0,        2, 32'h00000066, 1'b0, 0, 7'd0,   32'h0});
        vecs.push_back('{"err_half",    1'b1, 2'd1, 1'b0, 32'h15,  32'h1111,     1, 32'h0,        1'b1, 0, 7'd0,   32'h0});
        vecs.push_back('{"err_word",    1'b1, 2'd2, 1'b0, 32'h12,  32'h2222,     1, 32'h0,        1'b1, 0, 7'd0,   32'h0});
        vecs.push_back('{"err_size",    1'b0, 2'd3, 1'b0, 32'h10,  32'h0,        1, 32'h0,        1'b1, 0, 7'd0,   32'h0});
        vecs.push_back('{"err_range",   1'b1, 2'd2, 1'b0, 32'h200, 32'h3333,     1, 32'h0,        1'b1, 0, 7'd0,   32'h0});
        vecs.push_back('{"st_top",      1'b1, 2'd2, 1'b0, 32'h1FC, 32'hCAFEF00D, 2, 32'h0,        1'b0, 1, 7'd127, 32'hCAFEF00D});
        vecs.push_back('{"ld_top",      1'b0, 2'd2, 1'b0, 32'h1FC, 32'h0,        2, 32'hCAFEF00D, 1'b0, 0, 7'd0,   32'h0});
        vecs.push_back('{"st_word20",   1'b1, 2'd2, 1'b0, 32'h20,  32'h11223344, 2, 32'h0,        1'b0, 1, 7'd8,   32'h11223344});

        foreach (vecs[i]) begin
            w0 = wr_count;
            do_req(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, lat, rdata, err);
            check({vecs[i].tag, "_latency"}, 32'(lat), 32'(vecs[i].lat));
            check({vecs[i].tag, "_rdata"}, rdata, vecs[i].rdata);
            check({vecs[i].tag, "_err"}, 32'(err), 32'(vecs[i].err));
            @(posedge clk);
            #1;
            check({vecs[i].tag, "_writes"}, 32'(wr_count - w0), 32'(vecs[i].writes));
            if (vecs[i].writes != 0) begin
                check({vecs[i].tag, "_waddr"}, 32'(last_addr), 32'(vecs[i].waddr));
                check({vecs[i].tag, "_wdata"}, last_data, vecs[i].wval);
            end
        end

        // Abort a halfword store to 0x20 while it sits in MERGE_WR.
        w0 = wr_count;
        r0 = resp_count;
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_we       = 1'b1;
        bus.req_size     = 2'd1;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h20;
        bus.req_wdata    = 32'h0000AAAA;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_mem_wr", 32'(bus.mem_wr), 32'd0);
        check("abort_req_ready", 32'(bus.req_ready), 32'd0);
        check("abort_mem_data", bus.mem_write_data, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_ready_after", 32'(bus.req_ready), 32'd1);
        check("abort_writes", 32'(wr_count - w0), 32'd0);
        check("abort_resps", 32'(resp_count - r0), 32'd0);
        check("abort_word8", mem[8], 32'h11223344);
        do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, lat, rdata, err);
        check("abort_reload", rdata, 32'h11223344);

        // Hold req_valid high across four back-to-back word loads.
        @(negedge clk);
        @(negedge clk);
        a0 = accept_count;
        r0 = resp_count;
        bus.req_valid    = 1'b1;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'd2;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h14;
        repeat (12) @(posedge clk);
        #1 bus.req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("held_accepts", 32'(accept_count - a0), 32'd4);
        check("held_resps", 32'(resp_count - r0), 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the word width; only 32 is supported.
REQ-002 The block SHALL have parameter DATA_DEPTH, default 128, meaning the number of words in the downstream data_memory.
REQ-003 The block SHALL have derived parameter INDEX_WIDTH, default $clog2(DATA_DEPTH), meaning the word-index width.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset, with ports as follows:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- req_valid  input  1  core request present.
- req_ready  output  1  block can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_unsigned  input  1  zero-extend loads when 1, sign-extend when 0.
- req_addr  input  32  byte address.
- req_wdata  input  DATA_WIDTH  store data, right-aligned.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  DATA_WIDTH  extended load data.
- resp_err  output  1  request rejected.
- mem_address  output  INDEX_WIDTH  to data_memory address.
- mem_write_data  output  DATA_WIDTH  to data_memory write_data.
- mem_wr  output  1  to data_memory wr.
- mem_read_data  input  DATA_WIDTH  from data_memory read_data, combinational on mem_address.

Function
REQ-005 The FSM SHALL have states IDLE, ACCESS, MERGE_WR and RESP, and SHALL reset to IDLE.
REQ-006 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted on a rising edge where req_valid and req_ready are both 1, and all req_* fields SHALL be registered at that edge.
REQ-007 The word index SHALL be req_addr[INDEX_WIDTH+1:2], and the byte lane SHALL be req_addr[1:0] in little-endian order.
REQ-008 The accepted request SHALL be an error when any of the following holds:
- req_size = 11;
- a halfword with addr[0] = 1;
- a word with addr[1:0] != 0;
- req_addr >= 4*DATA_DEPTH.
REQ-009 For an error request, IDLE SHALL go directly to RESP with resp_err = 1 and resp_rdata = 0, and mem_wr SHALL never assert.
REQ-010 For a non-error request, IDLE SHALL go to ACCESS, and mem_address SHALL equal the registered word index throughout ACCESS and MERGE_WR.
REQ-011 A load in ACCESS SHALL capture mem_read_data, select the addressed byte or halfword lane, extend it to 32 bits per req_unsigned, and go to RESP; a word load SHALL ignore req_unsigned.
REQ-012 A word store in ACCESS SHALL drive mem_wr = 1 and mem_write_data = the registered wdata for exactly that cycle, then go to RESP.
REQ-013 A byte or halfword store in ACCESS SHALL capture mem_read_data, replace only the addressed lane(s) with wdata[7:0] or wdata[15:0], and go to MERGE_WR.
REQ-014 MERGE_WR SHALL drive mem_wr = 1 with the merged word for exactly one cycle, then go to RESP.
REQ-015 RESP SHALL assert resp_valid for exactly one cycle; for successful loads resp_rdata SHALL hold the extended data, for stores it SHALL be 0, and resp_err SHALL be 0. RESP SHALL then return to IDLE.
REQ-016 Latency from the accept edge to resp_valid high SHALL be:
- error: 1 cycle;
- load or word store: 2 cycles;
- byte or halfword store: 3 cycles.
REQ-017 Throughput SHALL be one request at a time; req_valid while req_ready = 0 SHALL be ignored, not queued.
REQ-018 Outside ACCESS and MERGE_WR, mem_wr SHALL be 0, mem_address SHALL be 0 and mem_write_data SHALL be 0; mem_wr SHALL be 0 in ACCESS for loads and sub-word stores.
REQ-019 resp_valid, resp_err and resp_rdata SHALL be 0 in all states other than RESP.

Reset
REQ-020 Asserting rst SHALL immediately force state IDLE, with req_ready = 0 while rst is high, and with resp_valid, resp_err, resp_rdata, mem_wr, mem_address and mem_write_data all 0.
REQ-021 rst asserted mid-operation SHALL abort the request with no memory write and no response; a partially merged word SHALL be discarded.
REQ-022 req_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-023 Store word 0xDEADBEEF at addr 0x14 -> mem_wr pulses once with mem_address 5 and mem_write_data 0xDEADBEEF, and resp_valid fires 2 cycles after accept; a following word load at 0x14 returns 0xDEADBEEF.
REQ-024 With word 5 = 0xDEADBEEF, store byte 0x55 at 0x16 -> a single write of 0xDE55BEEF at index 5, and resp_valid fires 3 cycles after accept.
REQ-025 With word 5 = 0xDE55BEEF, loads at 0x17 return as follows:
- signed byte -> 0xFFFFFFDE;
- unsigned byte -> 0x000000DE;
- signed halfword at 0x16 -> 0xFFFFDE55.
REQ-026 Each of the following returns resp_err = 1 after 1 cycle with no mem_wr pulse:
- halfword at 0x15;
- word at 0x12;
- size 11;
- address 0x200 with DATA_DEPTH = 128.
REQ-027 Assert rst during MERGE_WR of a halfword store to 0x20 -> no mem_wr pulse, no resp_valid, word 8 unchanged, and req_ready = 1 one cycle after rst releases.
REQ-028 Hold req_valid high continuously over several requests -> every request completes, and no request is accepted while req_ready = 0.
